// File: rtl/contador_programa_pkg.sv
// contador_programa_pkg
//   Shared definitions for the program-counter / process-context unit:
//   the controle_pc command encodings and the unit's state enum.
package contador_programa_pkg;

  // controle_pc commands issued by the control unit
  localparam logic [2:0] PC_INCR   = 3'b000;
  localparam logic [2:0] PC_SALTO  = 3'b001;
  localparam logic [2:0] PC_DESVIO = 3'b010;
  localparam logic [2:0] PC_PARA   = 3'b011;
  localparam logic [2:0] PC_HD     = 3'b100;
  localparam logic [2:0] PC_TROCA  = 3'b101;

  typedef enum logic [2:0] {
    EXEC,
    SALVA,
    RESTAURA,
    CARREGA_HD,
    PARADO
  } estado_t;

endpackage

// File: rtl/contador_programa_tabela.sv
// tabela_contexto
//   Per-process saved-PC register file: NUM_PROC entries of PC_WIDTH bits,
//   one synchronous write port, one asynchronous read port, all entries
//   cleared by the asynchronous reset.
// Ports:
//   clock, reset      : clock (rising edge) and async active-high reset
//   we, waddr, wdata  : write enable, entry index, value to store
//   raddr, rdata      : combinational read of entry raddr
module tabela_contexto #(
  parameter int PC_WIDTH   = 10,
  parameter int NUM_PROC   = 4,
  parameter int PROC_WIDTH = $clog2(NUM_PROC)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [PROC_WIDTH-1:0] waddr,
  input  logic [PC_WIDTH-1:0]   wdata,
  input  logic [PROC_WIDTH-1:0] raddr,
  output logic [PC_WIDTH-1:0]   rdata
);

  logic [PC_WIDTH-1:0] mem [NUM_PROC];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROC; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/contador_programa.sv
// contador_programa
//   Program counter and process-context sequencer. Decodes controle_pc each
//   instruction cycle (habilita) and handles increment, jump, branch, halt,
//   HD program load and two-cycle context switches through tabela_contexto.
//   Optional time-slice preemption is compiled in with the macro
//   CONTADOR_PROGRAMA_PREEMPCAO_EN (default build: switches only on 101).
// Ports:
//   clock, reset     : clock (rising edge), async active-high reset
//   habilita         : instruction-cycle strobe
//   controle_pc      : command from the control unit
//   destino          : jump/branch target
//   flag_branch      : branch-taken result from the ULA
//   proc_novo        : target process for an explicit switch
//   hd_pronto        : HD transfer complete
//   pc               : current PC (registered)
//   processo_atual   : running process id
//   ocupado          : stalled (switch or HD load in progress)
//   parado           : halted
module contador_programa
  import contador_programa_pkg::*;
#(
  parameter int PC_WIDTH   = 10,
  parameter int NUM_PROC   = 4,
  parameter int PROC_WIDTH = $clog2(NUM_PROC),
  parameter int QUANTUM    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic [2:0]            controle_pc,
  input  logic [PC_WIDTH-1:0]   destino,
  input  logic                  flag_branch,
  input  logic [PROC_WIDTH-1:0] proc_novo,
  input  logic                  hd_pronto,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PROC_WIDTH-1:0] processo_atual,
  output logic                  ocupado,
  output logic                  parado
);

  if (QUANTUM < 1 || NUM_PROC < 2 || NUM_PROC > 16) begin : g_param_invalido
    $error("contador_programa: invalid QUANTUM or NUM_PROC");
  end

  estado_t               estado;
  logic [PROC_WIDTH-1:0] proc_alvo;
  logic [PC_WIDTH-1:0]   pc_mais_um;
  logic [PC_WIDTH-1:0]   tabela_rd;
  logic                  tabela_we;
  logic                  executa;
  logic                  eh_sequencial;
  logic                  preempta;

  assign pc_mais_um = pc + PC_WIDTH'(1);
  // The saved value is pc+1 so the preempted/switched process resumes after
  // the instruction that triggered the switch.
  assign tabela_we  = (estado == SALVA);
  assign executa    = (estado == EXEC) && habilita;
  // Plain sequential instructions (000, 110, 111) are the only ones a
  // quantum expiry may replace with an automatic switch.
  assign eh_sequencial = !(controle_pc inside {PC_SALTO, PC_DESVIO, PC_PARA,
                                               PC_HD, PC_TROCA});

  tabela_contexto #(
    .PC_WIDTH  (PC_WIDTH),
    .NUM_PROC  (NUM_PROC),
    .PROC_WIDTH(PROC_WIDTH)
  ) u_tabela (
    .clock(clock),
    .reset(reset),
    .we   (tabela_we),
    .waddr(processo_atual),
    .wdata(pc_mais_um),
    .raddr(proc_alvo),
    .rdata(tabela_rd)
  );

`ifdef CONTADOR_PROGRAMA_PREEMPCAO_EN
  localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  logic [QW-1:0] quantum_cnt;
  logic          expira;

  assign expira   = (quantum_cnt == QW'(QUANTUM - 1));
  assign preempta = executa && expira && eh_sequencial;

  // The counter saturates at QUANTUM-1 so an expiry that lands on a
  // jump/branch/halt/HD command is deferred to the next executed instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quantum_cnt <= '0;
    end else if (estado == RESTAURA) begin
      quantum_cnt <= '0;
    end else if (executa) begin
      if (preempta || controle_pc == PC_TROCA) quantum_cnt <= '0;
      else if (!expira)                        quantum_cnt <= quantum_cnt + QW'(1);
    end
  end
`else
  assign preempta = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc             <= '0;
      processo_atual <= '0;
      proc_alvo      <= '0;
      estado         <= EXEC;
      ocupado        <= 1'b0;
      parado         <= 1'b0;
    end else begin
      case (estado)
        EXEC: begin
          if (habilita) begin
            if (preempta) begin
              // pc held: SALVA stores pc+1 as the resume point
              proc_alvo <= processo_atual + PROC_WIDTH'(1);
              estado    <= SALVA;
              ocupado   <= 1'b1;
            end else begin
              case (controle_pc)
                PC_SALTO:  pc <= destino;
                PC_DESVIO: pc <= flag_branch ? destino : pc_mais_um;
                PC_PARA: begin
                  estado <= PARADO;
                  parado <= 1'b1;
                end
                PC_HD: begin
                  estado  <= CARREGA_HD;
                  ocupado <= 1'b1;
                end
                PC_TROCA: begin
                  proc_alvo <= proc_novo;
                  estado    <= SALVA;
                  ocupado   <= 1'b1;
                end
                default:   pc <= pc_mais_um;
              endcase
            end
          end
        end
        SALVA: estado <= RESTAURA;
        RESTAURA: begin
          // table write from SALVA is already visible, so a switch to the
          // same process resumes at pc+1
          pc             <= tabela_rd;
          processo_atual <= proc_alvo;
          estado         <= EXEC;
          ocupado        <= 1'b0;
        end
        CARREGA_HD: begin
          if (hd_pronto) begin
            pc      <= '0;
            estado  <= EXEC;
            ocupado <= 1'b0;
          end
        end
        PARADO: ;
        default: estado <= EXEC;
      endcase
    end
  end

endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa
//   Scoreboard bench for contador_programa. The stimulus thread drives one
//   instruction cycle at a time, advances a behavioural reference model and
//   queues the expected outputs; a monitor on the falling edge pops and
//   compares. Directed sequences are followed by randomized traffic.
//   Define CONTADOR_PROGRAMA_PREEMPCAO_EN to exercise the preemption build.
module tb_contador_programa;
  import contador_programa_pkg::*;

  localparam int PCW = 10;
  localparam int NP  = 4;
  localparam int PW  = 2;
  localparam int Q   = 4;
  localparam int M   = 1 << PCW;
`ifdef CONTADOR_PROGRAMA_PREEMPCAO_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           habilita;
  logic [2:0]     controle_pc;
  logic [PCW-1:0] destino;
  logic           flag_branch;
  logic [PW-1:0]  proc_novo;
  logic           hd_pronto;
  logic [PCW-1:0] pc;
  logic [PW-1:0]  processo_atual;
  logic           ocupado;
  logic           parado;

  contador_programa #(
    .PC_WIDTH  (PCW),
    .NUM_PROC  (NP),
    .PROC_WIDTH(PW),
    .QUANTUM   (Q)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .controle_pc   (controle_pc),
    .destino       (destino),
    .flag_branch   (flag_branch),
    .proc_novo     (proc_novo),
    .hd_pronto     (hd_pronto),
    .pc            (pc),
    .processo_atual(processo_atual),
    .ocupado       (ocupado),
    .parado        (parado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [PW-1:0]  proc;
    logic           ocupado;
    logic           parado;
  } resp_t;

  resp_t esperado_q[$];
  resp_t mon_e;
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string nome, logic [31:0] atual, logic [31:0] req);
    checks++;
    if (atual !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, req, $time);
    end
  endfunction

  function automatic void chk_estado(string nome, int epc, int eproc, bit eoc, bit epar);
    chk({nome, ".pc"},      32'(pc),             epc);
    chk({nome, ".proc"},    32'(processo_atual), eproc);
    chk({nome, ".ocupado"}, 32'(ocupado),        32'(eoc));
    chk({nome, ".parado"},  32'(parado),         32'(epar));
  endfunction

  // Reference model: a switch is a countdown of busy cycles (2 = saving,
  // 1 = restoring); the HD load and halt are simple flags.
  int m_pc, m_proc, m_alvo, m_troca, m_q;
  bit m_hd, m_halt;
  int m_tab[NP];

  function automatic void model_reset();
    m_pc = 0; m_proc = 0; m_alvo = 0; m_troca = 0; m_q = 0;
    m_hd = 0; m_halt = 0;
    for (int i = 0; i < NP; i++) m_tab[i] = 0;
  endfunction

  function automatic void model_step(bit h, int cmd, int dst, bit fb, int pn, bit hdp);
    bit plain;
    if (m_halt) return;
    if (m_troca == 2) begin
      m_tab[m_proc] = (m_pc + 1) % M;
      m_troca = 1;
      return;
    end
    if (m_troca == 1) begin
      m_pc = m_tab[m_alvo];
      m_proc = m_alvo;
      m_troca = 0;
      m_q = 0;
      return;
    end
    if (m_hd) begin
      if (hdp) begin m_pc = 0; m_hd = 0; end
      return;
    end
    if (!h) return;
    plain = !(cmd inside {1, 2, 3, 4, 5});
    if (PREEMPT) begin
      if (m_q == Q - 1 && plain) begin
        m_alvo = (m_proc + 1) % NP;
        m_troca = 2;
        m_q = 0;
        return;
      end
      if (cmd == 5) m_q = 0;
      else if (m_q < Q - 1) m_q++;
    end
    case (cmd)
      1: m_pc = dst % M;
      2: m_pc = fb ? dst % M : (m_pc + 1) % M;
      3: m_halt = 1;
      4: m_hd = 1;
      5: begin m_alvo = pn % NP; m_troca = 2; end
      default: m_pc = (m_pc + 1) % M;
    endcase
  endfunction

  task automatic step(bit h, logic [2:0] cmd, int dst = 0, bit fb = 0, int pn = 0, bit hdp = 0);
    resp_t r;
    habilita    = h;
    controle_pc = cmd;
    destino     = dst[PCW-1:0];
    flag_branch = fb;
    proc_novo   = pn[PW-1:0];
    hd_pronto   = hdp;
    @(posedge clock);
    model_step(h, int'(cmd), dst & (M - 1), fb, pn & (NP - 1), hdp);
    r.pc      = PCW'(m_pc);
    r.proc    = PW'(m_proc);
    r.ocupado = (m_troca != 0) || m_hd;
    r.parado  = m_halt;
    esperado_q.push_back(r);
    #1;
  endtask

  // Asserts reset between edges and checks the outputs clear with no edge.
  task automatic do_reset_check(string nome);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_estado(nome, 0, 0, 1'b0, 1'b0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && esperado_q.size() > 0) begin
      mon_e = esperado_q.pop_front();
      chk("sb.pc",      32'(pc),             32'(mon_e.pc));
      chk("sb.proc",    32'(processo_atual), 32'(mon_e.proc));
      chk("sb.ocupado", 32'(ocupado),        32'(mon_e.ocupado));
      chk("sb.parado",  32'(parado),         32'(mon_e.parado));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    logic [2:0]  cmd;
    reset = 1'b1; habilita = 1'b0; controle_pc = PC_INCR; destino = '0;
    flag_branch = 1'b0; proc_novo = '0; hd_pronto = 1'b0;
    model_reset();
    #1;
    chk_estado("reset", 0, 0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

`ifdef CONTADOR_PROGRAMA_PREEMPCAO_EN
    repeat (3) step(1, PC_INCR);
    step(1, PC_INCR);
    chk_estado("expira4", 3, 0, 1'b1, 1'b0);
    repeat (2) step(1, PC_INCR);
    chk_estado("auto_troca", 0, 1, 1'b0, 1'b0);
    repeat (3) step(1, PC_INCR);
    step(1, PC_SALTO, 'h50);
    chk_estado("expira_salto", 'h50, 1, 1'b0, 1'b0);
    step(1, PC_INCR);
    chk_estado("adiada", 'h50, 1, 1'b1, 1'b0);
    repeat (2) step(1, PC_INCR);
    chk_estado("adiada_fim", 0, 2, 1'b0, 1'b0);
    repeat (3) step(1, PC_INCR);
    step(1, PC_TROCA, 0, 0, 0);
    repeat (2) step(1, PC_INCR);
    chk_estado("explicita_vence", 4, 0, 1'b0, 1'b0);
`else
    repeat (5) step(1, PC_INCR);
    chk_estado("incr5", 5, 0, 1'b0, 1'b0);
    step(1, PC_SALTO, 1023);
    step(1, PC_INCR);
    chk_estado("wrap", 0, 0, 1'b0, 1'b0);
    step(1, PC_SALTO, 'h2A);
    chk_estado("salto", 'h2A, 0, 1'b0, 1'b0);
    step(1, PC_DESVIO, 7, 0);
    chk_estado("desvio_nao", 'h2B, 0, 1'b0, 1'b0);
    step(1, PC_DESVIO, 7, 1);
    chk_estado("desvio_sim", 7, 0, 1'b0, 1'b0);
    step(0, PC_SALTO, 100);
    chk_estado("habilita0", 7, 0, 1'b0, 1'b0);
    step(1, PC_SALTO, 9);
    step(1, PC_TROCA, 0, 0, 2);
    chk_estado("salva", 9, 0, 1'b1, 1'b0);
    step(1, PC_SALTO, 500);
    chk_estado("restaura", 9, 0, 1'b1, 1'b0);
    step(1, PC_SALTO, 500);
    chk_estado("troca_p2", 0, 2, 1'b0, 1'b0);
    repeat (4) step(1, PC_INCR);
    step(1, PC_TROCA, 0, 0, 0);
    repeat (2) step(1, PC_INCR);
    chk_estado("troca_p0", 10, 0, 1'b0, 1'b0);
    step(1, PC_HD);
    repeat (6) begin
      step(1, PC_SALTO, 3);
      chk_estado("hd_espera", 10, 0, 1'b1, 1'b0);
    end
    step(1, PC_INCR, 0, 0, 0, 1);
    chk_estado("hd_pronto", 0, 0, 1'b0, 1'b0);
    step(1, PC_SALTO, 'h15);
    step(1, PC_PARA);
    chk_estado("para", 'h15, 0, 1'b0, 1'b1);
    repeat (10) begin
      step(1, PC_SALTO, 77, 0, 1, 1);
      chk_estado("parado_fixo", 'h15, 0, 1'b0, 1'b1);
    end
    do_reset_check("reset_parado");
    step(1, PC_SALTO, 20);
    step(1, PC_TROCA, 0, 0, 1);
    repeat (2) step(1, PC_INCR);
    step(1, PC_SALTO, 33);
    step(1, PC_TROCA, 0, 0, 3);
    repeat (2) step(1, PC_INCR);
    step(1, PC_SALTO, 40);
    step(1, PC_TROCA, 0, 0, 2);
    chk_estado("antes_reset_salva", 40, 3, 1'b1, 1'b0);
    do_reset_check("reset_salva");
    step(1, PC_TROCA, 0, 0, 1);
    repeat (2) step(1, PC_INCR);
    chk_estado("tabela_zerada", 0, 1, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 1500; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset_check("reset_rand");
      r = int'($urandom_range(0, 99));
      if      (r < 40) cmd = PC_INCR;
      else if (r < 55) cmd = PC_SALTO;
      else if (r < 70) cmd = PC_DESVIO;
      else if (r < 72) cmd = PC_PARA;
      else if (r < 79) cmd = PC_HD;
      else if (r < 92) cmd = PC_TROCA;
      else if (r < 96) cmd = 3'b110;
      else             cmd = 3'b111;
      step($urandom_range(0, 9) != 0, cmd, int'($urandom_range(0, M - 1)),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, NP - 1)),
           $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clock);
    #1;
    chk("sb.drain", 32'(esperado_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_programa.md
# contador_programa

Program-counter and process-context unit that consumes the 3-bit `controle_pc` command from the control unit every instruction cycle. It holds the current PC and a per-process saved-PC table, and sequences jumps, branches, halt, HD program load and context switches. It drives the instruction-memory address and the current process id back to the fetch stage.

## Interface
Parameters:
- `PC_WIDTH`, 10: PC width in bits.
- `NUM_PROC`, 4: number of process contexts; power of two, 2..16.
- `PROC_WIDTH`, $clog2(NUM_PROC): process id width.
- `QUANTUM`, 16: instructions per time slice. Used only with preemption compiled in.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `habilita` in 1: instruction-cycle strobe. The PC advances only when this is 1.
- `controle_pc` in 3: command from the control unit.
- `destino` in PC_WIDTH: jump/branch target.
- `flag_branch` in 1: branch-taken result from the ULA.
- `proc_novo` in PROC_WIDTH: target process for a context switch.
- `hd_pronto` in 1: HD transfer complete.
- `pc` out PC_WIDTH: current PC (registered).
- `processo_atual` out PROC_WIDTH: running process id.
- `ocupado` out 1: unit stalled; fetch must hold.
- `parado` out 1: halted.

## Operation
- Reset values: `pc`=0, every table entry=0, `processo_atual`=0, `ocupado`=0, `parado`=0, state EXEC, quantum counter=0.
- States:
  - EXEC: normal execution.
  - SALVA: first context-switch cycle.
  - RESTAURA: second context-switch cycle.
  - CARREGA_HD: waiting for an HD transfer.
  - PARADO: halted.
- In EXEC with `habilita`=1, `controle_pc` is decoded as follows:
  - 000: `pc`<=pc+1.
  - 001: `pc`<=`destino`.
  - 010: `pc`<=`destino` if `flag_branch` is 1, else pc+1.
  - 011: go to PARADO and hold `pc`.
  - 100: go to CARREGA_HD and hold `pc`.
  - 101: latch `proc_novo` and go to SALVA.
  - 110 and 111: treated as 000.
- In EXEC with `habilita`=0: hold everything.
- SALVA: table[processo_atual]<=pc+1, then go to RESTAURA.
- RESTAURA: `pc`<=table[latched proc_novo], `processo_atual`<=latched id, then go to EXEC.
- Switching to the same process is legal. The result is pc+1.
- CARREGA_HD: stay until `hd_pronto`=1, then `pc`<=0 and go to EXEC. `hd_pronto` is ignored in all other states.
- PARADO: terminal. Only `reset` exits it.
- `ocupado`=1 in SALVA, RESTAURA and CARREGA_HD.
- `parado`=1 in PARADO.
- PC arithmetic is modulo 2^PC_WIDTH: max+1 wraps to 0, with no flag.
- `reset` asserted in any state, including mid-switch, returns every register to its reset value immediately.

## Timing
- `pc` changes on the rising edge after the command is sampled. Latency is 1 cycle for 000/001/010.
- Context switch takes 2 cycles with `ocupado` high. The new PC is visible on the edge ending RESTAURA.
- CARREGA_HD: `pc`=0 is visible 1 cycle after the edge where `hd_pronto` is sampled high.
- `habilita` is ignored while `ocupado`=1 or `parado`=1.

## Configuration
- `CONTADOR_PROGRAMA_PREEMPCAO_EN` defined: a quantum counter increments on every executed EXEC instruction.
  - When the count reaches QUANTUM-1 on an executed instruction that is not a branch/jump/halt/HD/switch, the unit enters SALVA with target (processo_atual+1) mod NUM_PROC. The counter clears.
  - An explicit 101 clears the counter, and the explicit target wins when expiry coincides with it.
  - Expiry coinciding with 001/010/011/100: the explicit command executes and preemption is deferred to the next executed instruction.
  - The counter clears on every completed switch.
- Undefined: no counter. Switches happen only on 101.

## Structure
- Shared package `contador_programa_pkg` contains:
  - `controle_pc` encodings as named constants: PC_INCR, PC_SALTO, PC_DESVIO, PC_PARA, PC_HD, PC_TROCA.
  - The state enum.
- Sub-module `tabela_contexto`: NUM_PROC×PC_WIDTH register file, 1 write port and 1 asynchronous read port, asynchronous reset to 0.

## Test plan
- Reset, then 5 cycles of 000 with `habilita`=1 → `pc`=5. With `pc` at 1023 (PC_WIDTH=10), one 000 → `pc`=0.
- 001 with `destino`=0x2A → `pc`=0x2A. Then 010 with `flag_branch`=0 → 0x2B; 010 with `flag_branch`=1, `destino`=7 → 7.
- Context switch: `pc`=9 in process 0, 101 with `proc_novo`=2 → `ocupado` high 2 cycles, `pc`=0, `processo_atual`=2. Then `pc` to 4 and 101 back to 0 → `pc`=10, `processo_atual`=0.
- 100, hold `hd_pronto`=0 for 6 cycles → `pc` held and `ocupado`=1. Assert `hd_pronto` → next cycle `pc`=0, `ocupado`=0. Then 011 → `parado`=1 and `pc` frozen for 10 cycles.
- Assert `reset` during SALVA → `pc`=0, `processo_atual`=0, `ocupado`=0 with no clock edge needed.
- With PREEMPCAO_EN and QUANTUM=4, four 000 instructions in process 0 → automatic switch to process 1 with `pc`=0. Expiry landing on 001 → jump taken, switch follows the next instruction.
